// File: rtl/gci_specialmem_pkg.sv
// gci_specialmem_pkg: special-memory map addresses, error codes and scanner states
package gci_specialmem_pkg;
  localparam logic [9:0] ADDR_INFO        = 10'h000;
  localparam logic [9:0] ADDR_TOTAL       = 10'h004;
  localparam logic [9:0] ADDR_NODE_BASE   = 10'h100;
  localparam logic [9:0] ADDR_NODE_STRIDE = 10'h020;
  localparam logic [9:0] ADDR_PRIO_OFS    = 10'h004;
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_MISMATCH = 2'd3;
  typedef enum logic [2:0] {
    S_IDLE, S_RD_INFO, S_RD_TOTAL, S_RD_SIZE, S_RD_PRIO, S_CHECK, S_DONE, S_ERROR
  } state_t;
endpackage

// File: rtl/gci_hub_specialmem_scanner_timeout.sv
// gci_hub_specialmem_scanner_timeout: per-read wait counter with clear/enable and expiry flag
module gci_hub_specialmem_scanner_timeout #(
  parameter int P_TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = $clog2(P_TIMEOUT) + 1;
  logic [W-1:0] r_cnt;
  assign o_expired = r_cnt == W'(P_TIMEOUT - 1);
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_cnt <= '0;
    else if (i_en && !o_expired) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/gci_hub_specialmem_scanner.sv
// gci_hub_specialmem_scanner: walks the special-memory map and builds the node size/base/priority table
module gci_hub_specialmem_scanner
  import gci_specialmem_pkg::*;
#(
  parameter int          P_NODES        = 4,
  parameter int          P_TIMEOUT      = 16,
  parameter logic [31:0] P_SPECIAL_SIZE = 32'h400
) (
  input  logic                   iCLOCK,
  input  logic                   iRESET_SYNC,
  input  logic                   iSTART,
  output logic                   oBUSY,
  output logic                   oDONE,
  output logic                   oERROR,
  output logic [1:0]             oERROR_CODE,
  output logic                   oREAD_REQ,
  output logic [9:0]             oREAD_ADDR,
  input  logic                   iDATA_VALID,
  input  logic [31:0]            iDATA,
  output logic [2:0]             oNODE_NUM,
  output logic [32*P_NODES-1:0]  oNODE_SIZE,
  output logic [32*P_NODES-1:0]  oNODE_BASE,
  output logic [8*P_NODES-1:0]   oNODE_PRIORITY,
  output logic [P_NODES-1:0]     oNODE_VALID
);
  state_t                r_state;
  logic [2:0]            r_idx, r_num;
  logic [31:0]           r_acc, r_total;
  logic [32*P_NODES-1:0] r_size, r_base;
  logic [8*P_NODES-1:0]  r_prio;
  logic [P_NODES-1:0]    r_valid;
  logic                  r_done, r_error;
  logic [1:0]            r_code;
  logic                  w_rd, w_beat, w_expired;
  logic [8:0]            w_count;
  logic [9:0]            w_node_addr;
  assign w_rd        = r_state inside {S_RD_INFO, S_RD_TOTAL, S_RD_SIZE, S_RD_PRIO};
  assign w_beat      = w_rd & iDATA_VALID;
  assign w_count     = {1'b0, iDATA[7:0]} + 9'd1;
  assign w_node_addr = ADDR_NODE_BASE + 10'(r_idx) * ADDR_NODE_STRIDE;
  assign oBUSY          = w_rd | (r_state == S_CHECK);
  assign oDONE          = r_done;
  assign oERROR         = r_error;
  assign oERROR_CODE    = r_code;
  assign oREAD_REQ      = w_rd;
  assign oREAD_ADDR     = r_state == S_RD_TOTAL ? ADDR_TOTAL :
                          r_state == S_RD_SIZE  ? w_node_addr :
                          r_state == S_RD_PRIO  ? w_node_addr + ADDR_PRIO_OFS : ADDR_INFO;
  assign oNODE_NUM      = r_num;
  assign oNODE_SIZE     = r_size;
  assign oNODE_BASE     = r_base;
  assign oNODE_PRIORITY = r_prio;
  assign oNODE_VALID    = r_valid;
  // The counter restarts on every completed beat, so each RD_* state gets a full window
  gci_hub_specialmem_scanner_timeout #(.P_TIMEOUT(P_TIMEOUT)) u_timeout (
    .i_clk     (iCLOCK),
    .i_rst     (iRESET_SYNC),
    .i_clr     (w_beat | ~w_rd),
    .i_en      (w_rd),
    .o_expired (w_expired)
  );
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_num   <= '0;
      r_acc   <= '0;
      r_total <= '0;
      r_size  <= '0;
      r_base  <= '0;
      r_prio  <= '0;
      r_valid <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_code  <= ERR_NONE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          r_done  <= r_state == S_DONE;
          r_error <= r_state == S_ERROR;
          if (iSTART) begin
            r_state <= S_RD_INFO;
            r_idx   <= '0;
            r_num   <= '0;
            r_acc   <= '0;
            r_total <= '0;
            r_size  <= '0;
            r_base  <= '0;
            r_prio  <= '0;
            r_valid <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_code  <= ERR_NONE;
          end
        end
        S_RD_INFO: if (w_beat) begin
          if (w_count > 9'(P_NODES)) begin
            r_state <= S_ERROR;
            r_code  <= ERR_OVERFLOW;
          end else begin
            r_num   <= w_count[2:0];
            r_idx   <= '0;
            r_acc   <= P_SPECIAL_SIZE;
            r_state <= S_RD_TOTAL;
          end
        end
        S_RD_TOTAL: if (w_beat) begin
          r_total <= iDATA;
          r_state <= S_RD_SIZE;
        end
        S_RD_SIZE: if (w_beat) begin
          r_size[32*r_idx +: 32] <= iDATA;
          r_base[32*r_idx +: 32] <= r_acc;
          r_acc   <= r_acc + iDATA;
          r_state <= S_RD_PRIO;
        end
        S_RD_PRIO: if (w_beat) begin
          r_prio[8*r_idx +: 8] <= iDATA[7:0];
          r_valid <= r_valid | (P_NODES'(1) << r_idx);
          r_idx   <= r_idx + 3'd1;
          r_state <= (4'(r_idx) + 4'd1 < 4'(r_num)) ? S_RD_SIZE : S_CHECK;
        end
        S_CHECK: begin
          r_state <= r_acc != r_total ? S_ERROR : S_DONE;
          r_code  <= r_acc != r_total ? ERR_MISMATCH : ERR_NONE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_rd && !iDATA_VALID && w_expired) begin
        r_state <= S_ERROR;
        r_code  <= ERR_TIMEOUT;
      end
    end
  end
endmodule

// File: tb/tb_gci_hub_specialmem_scanner.sv
// tb_gci_hub_specialmem_scanner: scoreboarded scenarios against a programmable read responder
module tb_gci_hub_specialmem_scanner;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, valid;
  logic [31:0] data;
  logic busy, done, err, req;
  logic [1:0] code;
  logic [9:0] addr;
  logic [2:0] num;
  logic [127:0] nsize, nbase;
  logic [31:0] nprio;
  logic [3:0] nvalid;
  int checks = 0, failures = 0;
  logic [31:0] m_info = '0, m_total = '0;
  logic [31:0] m_size [4];
  logic [7:0] m_prio [4];
  logic [9:0] m_stall = 10'h3FF;
  int m_wait = 0, wcnt = 0, addr_bad = 0;
  logic held = 1'b0;
  logic [9:0] last_addr = '0;
  logic [9:0] exp_q [$];
  logic [127:0] es, eb;
  logic [31:0] ep;
  logic [3:0] ev;
  int cyc;

  always #5 clk = ~clk;

  gci_hub_specialmem_scanner dut (
    .iCLOCK(clk), .iRESET_SYNC(rst), .iSTART(start), .oBUSY(busy), .oDONE(done),
    .oERROR(err), .oERROR_CODE(code), .oREAD_REQ(req), .oREAD_ADDR(addr),
    .iDATA_VALID(valid), .iDATA(data), .oNODE_NUM(num), .oNODE_SIZE(nsize),
    .oNODE_BASE(nbase), .oNODE_PRIORITY(nprio), .oNODE_VALID(nvalid)
  );

  always_comb begin
    data = 32'hDEAD_BEEF;
    if (addr == 10'h000) data = m_info;
    if (addr == 10'h004) data = m_total;
    for (int n = 0; n < 4; n++) begin
      if (addr == 10'(256 + 32 * n)) data = m_size[n];
      if (addr == 10'(260 + 32 * n)) data = {24'hA5A5A5, m_prio[n]};
    end
  end
  assign valid = req && (wcnt >= m_wait) && (addr != m_stall);
  always @(posedge clk) wcnt <= (rst || !req || valid) ? 0 : wcnt + 1;

  // Every completed beat must match the next expected address; a waiting address must not move
  always @(negedge clk) begin
    if (req && held && addr !== last_addr) addr_bad++;
    if (req && valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_addr: got %h, expected no read", addr);
      end else begin
        if (addr !== exp_q[0]) begin
          failures++;
          $display("FAIL beat_addr: got %h, expected %h", addr, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    held <= req && !valid;
    last_addr <= addr;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic cfg(input logic [31:0] info, input logic [31:0] total, input int wt, input logic [9:0] stall);
    m_info = info; m_total = total; m_wait = wt; m_stall = stall;
    m_size[0] = 32'h100; m_size[1] = 32'h200; m_size[2] = 32'h300; m_size[3] = 32'h400;
    m_prio[0] = 8'd1; m_prio[1] = 8'd2; m_prio[2] = 8'd3; m_prio[3] = 8'd4;
  endtask

  task automatic model(input int ns, input int np);
    logic [31:0] acc;
    acc = 32'h400; es = '0; eb = '0; ep = '0; ev = '0;
    for (int n = 0; n < ns; n++) begin
      es[32*n +: 32] = m_size[n];
      eb[32*n +: 32] = acc;
      acc = acc + m_size[n];
    end
    for (int n = 0; n < np; n++) begin
      ep[8*n +: 8] = m_prio[n];
      ev[n] = 1'b1;
    end
  endtask

  task automatic push_addrs(input int ns, input int np);
    exp_q.push_back(10'h000);
    exp_q.push_back(10'h004);
    for (int n = 0; n < ns; n++) begin
      exp_q.push_back(10'(256 + 32 * n));
      if (n < np) exp_q.push_back(10'(260 + 32 * n));
    end
  endtask

  // cyc = number of edges after the one that sampled iSTART until oDONE/oERROR is seen
  task automatic run_scan(input bit mid, output int c);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0; c = 0;
    while (!(done || err) && c < 200) begin
      start = mid && c == 5;
      @(negedge clk); c++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, err, code, req, addr, num, nsize, nbase, nprio, nvalid} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b code=%0d req=%b addr=%h num=%0d valid=%h, expected all zero",
               busy, done, err, code, req, addr, num, nvalid);
    end
    rst = 1'b0;
  endtask

  task automatic test_happy;
    cfg(32'h1234_5603, 32'hE00, 0, 10'h3FF);
    push_addrs(4, 4);
    model(4, 4);
    run_scan(1'b0, cyc);
    checks++; if (cyc !== 12) begin failures++; $display("FAIL happy_latency: got %0d, expected 12", cyc); end
    checks++; if ({done, err, code, busy} !== 5'b10000) begin failures++; $display("FAIL happy_status: done=%b err=%b code=%0d busy=%b, expected 1 0 0 0", done, err, code, busy); end
    checks++; if (num !== 3'd4 || nvalid !== 4'hF) begin failures++; $display("FAIL happy_num: num=%0d valid=%h, expected 4 f", num, nvalid); end
    checks++; if (nbase !== 128'h00000A00_00000700_00000500_00000400) begin failures++; $display("FAIL happy_base: got %h, expected 00000a00000007000000050000000400", nbase); end
    checks++; if (nsize !== es || nprio !== 32'h04030201) begin failures++; $display("FAIL happy_size_prio: size=%h prio=%h, expected %h 04030201", nsize, nprio, es); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL happy_reads: %0d reads missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_wait_states;
    cfg(32'h3, 32'hE00, 3, 10'h3FF);
    push_addrs(4, 4);
    model(4, 4);
    addr_bad = 0;
    run_scan(1'b0, cyc);
    checks++; if (cyc !== 42) begin failures++; $display("FAIL wait_latency: got %0d, expected 42", cyc); end
    checks++; if (addr_bad !== 0) begin failures++; $display("FAIL wait_addr_stable: got %0d changes, expected 0", addr_bad); end
    checks++; if (!done || nbase !== eb || nsize !== es || nprio !== ep || nvalid !== ev) begin failures++; $display("FAIL wait_table: done=%b base=%h valid=%h, expected 1 %h %h", done, nbase, nvalid, eb, ev); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wait_reads: %0d reads missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_mismatch;
    cfg(32'h3, 32'h1300, 0, 10'h3FF);
    push_addrs(4, 4);
    model(4, 4);
    run_scan(1'b0, cyc);
    checks++; if ({done, err, code} !== 4'b0111) begin failures++; $display("FAIL mismatch_status: done=%b err=%b code=%0d, expected 0 1 3", done, err, code); end
    checks++; if (nvalid !== 4'hF || nbase !== eb) begin failures++; $display("FAIL mismatch_table: valid=%h base=%h, expected f %h", nvalid, nbase, eb); end
  endtask

  task automatic test_overflow;
    cfg(32'h4, 32'h0, 0, 10'h3FF);
    exp_q.push_back(10'h000);
    run_scan(1'b0, cyc);
    checks++; if (cyc !== 2 || {err, code} !== 3'b110) begin failures++; $display("FAIL overflow_status: cyc=%0d err=%b code=%0d, expected 2 1 2", cyc, err, code); end
    checks++; if (nvalid !== 4'h0 || num !== 3'd0 || req !== 1'b0) begin failures++; $display("FAIL overflow_table: valid=%h num=%0d req=%b, expected 0 0 0", nvalid, num, req); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL overflow_reads: %0d reads missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_timeout;
    cfg(32'h3, 32'hE00, 0, 10'h124);
    push_addrs(2, 1);
    model(2, 1);
    run_scan(1'b0, cyc);
    checks++; if (cyc !== 22 || {err, code} !== 3'b101) begin failures++; $display("FAIL timeout_status: cyc=%0d err=%b code=%0d, expected 22 1 1", cyc, err, code); end
    checks++; if (req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL timeout_req: req=%b busy=%b, expected 0 0", req, busy); end
    checks++; if (nvalid !== 4'h1 || nsize !== es || nbase !== eb || nprio !== ep) begin failures++; $display("FAIL timeout_table: valid=%h size=%h, expected 1 %h", nvalid, nsize, es); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL timeout_reads: %0d reads missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_mid_start;
    cfg(32'h3, 32'hE00, 0, 10'h3FF);
    push_addrs(4, 4);
    run_scan(1'b1, cyc);
    checks++; if (cyc !== 12 || done !== 1'b1) begin failures++; $display("FAIL midstart_latency: cyc=%0d done=%b, expected 12 1", cyc, done); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL midstart_reads: %0d reads missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    cfg(32'h3, 32'hE00, 0, 10'h3FF);
    push_addrs(4, 4);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 50 && addr !== 10'h140; c++) @(negedge clk);
    checks++; if (addr !== 10'h140) begin failures++; $display("FAIL rstmid_reach: addr=%h, expected 140", addr); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, err, code, req, addr, num, nsize, nbase, nprio, nvalid} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs: busy=%b req=%b num=%0d valid=%h size=%h, expected all zero", busy, req, num, nvalid, nsize);
    end
    rst = 1'b0;
    exp_q.delete();
    push_addrs(4, 4);
    model(4, 4);
    run_scan(1'b0, cyc);
    checks++; if (cyc !== 12 || done !== 1'b1 || nbase !== eb || nvalid !== ev) begin failures++; $display("FAIL rstmid_rescan: cyc=%0d done=%b base=%h, expected 12 1 %h", cyc, done, nbase, eb); end
  endtask

  task automatic test_wrap;
    cfg(32'h0, 32'h0, 0, 10'h3FF);
    m_size[0] = 32'hFFFF_FC00;
    push_addrs(1, 1);
    run_scan(1'b0, cyc);
    checks++; if (cyc !== 6 || {done, err, code} !== 4'b1000) begin failures++; $display("FAIL wrap_status: cyc=%0d done=%b err=%b code=%0d, expected 6 1 0 0", cyc, done, err, code); end
    checks++; if (nbase !== 128'h400 || nsize !== 128'hFFFF_FC00 || num !== 3'd1 || nvalid !== 4'h1) begin failures++; $display("FAIL wrap_table: base=%h size=%h num=%0d valid=%h, expected 400 fffffc00 1 1", nbase, nsize, num, nvalid); end
  endtask

  initial begin
    cfg(32'h0, 32'h0, 0, 10'h3FF);
    test_reset;
    test_happy;
    test_wait_states;
    test_mismatch;
    test_overflow;
    test_timeout;
    test_mid_start;
    test_reset_mid;
    test_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
